// File: rtl/spi_reg_controller.sv
// spi_reg_controller: turns the PICO byte stream (already in the iclk domain)
// into register-file writes and POCI mux select/load strobes. The first byte of
// a frame is the command (bit7 = read, bits[6:0] = start address); every later
// byte is write data, or a dummy byte that advances the read pointer.

module spi_reg_controller #(
    parameter int NUM_REGS = 16,
    parameter bit WRAP_EN  = 1'b1
) (
    input  logic       iclk,
    input  logic       rstn,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    input  logic       frame_end,
    output logic       reg_wr_en,
    output logic [6:0] reg_wr_addr,
    output logic [7:0] reg_wr_data,
    output logic [6:0] rd_sel,
    output logic       rd_load,
    output logic       busy,
    output logic       addr_err,
    output logic [7:0] wr_count
);

    localparam logic [7:0] NUM_REGS_B = 8'(NUM_REGS);
    localparam logic [6:0] LAST_ADDR  = 7'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WRITE = 2'd1,
        READ  = 2'd2,
        ERR   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [6:0] ptr_q, ptr_d;
    logic       reg_wr_en_q, reg_wr_en_d;
    logic [6:0] reg_wr_addr_q, reg_wr_addr_d;
    logic [7:0] reg_wr_data_q, reg_wr_data_d;
    logic [6:0] rd_sel_q, rd_sel_d;
    logic       rd_load_q, rd_load_d;
    logic       addr_err_q, addr_err_d;
    logic [7:0] wr_count_q, wr_count_d;

    // Register every piece of state, including the strobes, so outputs are glitch-free.
    always_ff @(posedge iclk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            reg_wr_en_q   <= 1'b0;
            reg_wr_addr_q <= '0;
            reg_wr_data_q <= '0;
            rd_sel_q      <= '0;
            rd_load_q     <= 1'b0;
            addr_err_q    <= 1'b0;
            wr_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            reg_wr_en_q   <= reg_wr_en_d;
            reg_wr_addr_q <= reg_wr_addr_d;
            reg_wr_data_q <= reg_wr_data_d;
            rd_sel_q      <= rd_sel_d;
            rd_load_q     <= rd_load_d;
            addr_err_q    <= addr_err_d;
            wr_count_q    <= wr_count_d;
        end
    end

    // Next-state logic: the byte is handled first, then frame_end forces IDLE and clears ptr.
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        reg_wr_en_d   = 1'b0;
        reg_wr_addr_d = reg_wr_addr_q;
        reg_wr_data_d = reg_wr_data_q;
        rd_sel_d      = rd_sel_q;
        rd_load_d     = 1'b0;
        addr_err_d    = addr_err_q;
        wr_count_d    = wr_count_q;

        case (state_q)
            IDLE: begin
                // A command arriving together with frame_end belongs to no frame and is dropped.
                if (byte_valid && !frame_end) begin
                    addr_err_d = 1'b0;
                    wr_count_d = '0;
                    if ({1'b0, byte_in[6:0]} >= NUM_REGS_B) begin
                        state_d    = ERR;
                        addr_err_d = 1'b1;
                    end else if (byte_in[7]) begin
                        state_d   = READ;
                        ptr_d     = byte_in[6:0];
                        rd_sel_d  = byte_in[6:0];
                        rd_load_d = 1'b1;
                    end else begin
                        state_d = WRITE;
                        ptr_d   = byte_in[6:0];
                    end
                end
            end

            WRITE: begin
                if (byte_valid) begin
                    reg_wr_en_d   = 1'b1;
                    reg_wr_addr_d = ptr_q;
                    reg_wr_data_d = byte_in;
                    if (wr_count_q != 8'hFF) begin
                        wr_count_d = wr_count_q + 8'd1;
                    end
                    if (ptr_q == LAST_ADDR) begin
                        if (WRAP_EN) begin
                            ptr_d = '0;
                        end else begin
                            state_d    = ERR;
                            addr_err_d = 1'b1;
                        end
                    end else begin
                        ptr_d = ptr_q + 7'd1;
                    end
                end
            end

            READ: begin
                // The dummy byte value is irrelevant; it only advances the read pointer.
                // Without wrap there is no register past the last one, so no load is issued.
                if (byte_valid) begin
                    if (ptr_q == LAST_ADDR) begin
                        if (WRAP_EN) begin
                            ptr_d     = '0;
                            rd_sel_d  = '0;
                            rd_load_d = 1'b1;
                        end else begin
                            state_d    = ERR;
                            addr_err_d = 1'b1;
                        end
                    end else begin
                        ptr_d     = ptr_q + 7'd1;
                        rd_sel_d  = ptr_q + 7'd1;
                        rd_load_d = 1'b1;
                    end
                end
            end

            ERR: begin
                state_d = ERR;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (frame_end) begin
            state_d = IDLE;
            ptr_d   = '0;
        end
    end

    assign reg_wr_en   = reg_wr_en_q;
    assign reg_wr_addr = reg_wr_addr_q;
    assign reg_wr_data = reg_wr_data_q;
    assign rd_sel      = rd_sel_q;
    assign rd_load     = rd_load_q;
    assign addr_err    = addr_err_q;
    assign wr_count    = wr_count_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_controller.sv
// Directed bench for spi_reg_controller. Two instances share the same inputs:
// u_dut wraps the address, u_nowrap enters ERR on overrun.

module tb_spi_reg_controller;

    logic       iclk;
    logic       rstn;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       frame_end;

    logic       reg_wr_en, rd_load, busy, addr_err;
    logic [6:0] reg_wr_addr, rd_sel;
    logic [7:0] reg_wr_data, wr_count;

    logic       nw_reg_wr_en, nw_rd_load, nw_busy, nw_addr_err;
    logic [6:0] nw_reg_wr_addr, nw_rd_sel;
    logic [7:0] nw_reg_wr_data, nw_wr_count;

    int checkCount = 0;
    int passCount  = 0;
    int failCount  = 0;

    spi_reg_controller #(.NUM_REGS(16), .WRAP_EN(1'b1)) u_dut (
        .iclk(iclk), .rstn(rstn), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_end(frame_end), .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
        .reg_wr_data(reg_wr_data), .rd_sel(rd_sel), .rd_load(rd_load),
        .busy(busy), .addr_err(addr_err), .wr_count(wr_count)
    );

    spi_reg_controller #(.NUM_REGS(16), .WRAP_EN(1'b0)) u_nowrap (
        .iclk(iclk), .rstn(rstn), .byte_in(byte_in), .byte_valid(byte_valid),
        .frame_end(frame_end), .reg_wr_en(nw_reg_wr_en), .reg_wr_addr(nw_reg_wr_addr),
        .reg_wr_data(nw_reg_wr_data), .rd_sel(nw_rd_sel), .rd_load(nw_rd_load),
        .busy(nw_busy), .addr_err(nw_addr_err), .wr_count(nw_wr_count)
    );

    // Free-running 10-unit clock; rising edges at 5, 15, 25, ...
    initial begin
        iclk = 1'b0;
        forever #5 iclk = ~iclk;
    end

    // Drive one cycle of inputs starting at a falling edge; returns at the next
    // falling edge, where the registered response to that cycle is visible.
    task automatic applyStimulus(input logic [7:0] b, input logic bv, input logic fe);
        byte_in    = b;
        byte_valid = bv;
        frame_end  = fe;
        @(negedge iclk);
        byte_valid = 1'b0;
        frame_end  = 1'b0;
    endtask

    task automatic idleCycle();
        applyStimulus(8'h00, 1'b0, 1'b0);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Directed sequence: reset, write, read, wrap/overrun, bad address, edge events.
    initial begin
        rstn       = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        frame_end  = 1'b0;
        repeat (2) @(negedge iclk);

        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_wr_en", 32'(reg_wr_en), 32'd0);
        checkOutput("rst_rd_load", 32'(rd_load), 32'd0);
        checkOutput("rst_rd_sel", 32'(rd_sel), 32'd0);
        checkOutput("rst_addr_err", 32'(addr_err), 32'd0);
        checkOutput("rst_wr_count", 32'(wr_count), 32'd0);
        rstn = 1'b1;
        idleCycle();

        $display("[TB] write burst 0x03,0xAA,0xBB");
        applyStimulus(8'h03, 1'b1, 1'b0);
        checkOutput("w_cmd_busy", 32'(busy), 32'd1);
        checkOutput("w_cmd_no_wr", 32'(reg_wr_en), 32'd0);
        applyStimulus(8'hAA, 1'b1, 1'b0);
        checkOutput("w1_en", 32'(reg_wr_en), 32'd1);
        checkOutput("w1_addr", 32'(reg_wr_addr), 32'd3);
        checkOutput("w1_data", 32'(reg_wr_data), 32'hAA);
        applyStimulus(8'hBB, 1'b1, 1'b0);
        checkOutput("w2_en", 32'(reg_wr_en), 32'd1);
        checkOutput("w2_addr", 32'(reg_wr_addr), 32'd4);
        checkOutput("w2_data", 32'(reg_wr_data), 32'hBB);
        checkOutput("w2_count", 32'(wr_count), 32'd2);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("w_end_busy", 32'(busy), 32'd0);
        checkOutput("w_end_count", 32'(wr_count), 32'd2);
        checkOutput("w_end_no_wr", 32'(reg_wr_en), 32'd0);

        $display("[TB] read burst 0x85,0x00,0x00");
        applyStimulus(8'h85, 1'b1, 1'b0);
        checkOutput("r0_sel", 32'(rd_sel), 32'd5);
        checkOutput("r0_load", 32'(rd_load), 32'd1);
        checkOutput("r0_count_clr", 32'(wr_count), 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("r1_sel", 32'(rd_sel), 32'd6);
        checkOutput("r1_load", 32'(rd_load), 32'd1);
        checkOutput("r1_no_wr", 32'(reg_wr_en), 32'd0);
        applyStimulus(8'h00, 1'b1, 1'b0);
        checkOutput("r2_sel", 32'(rd_sel), 32'd7);
        checkOutput("r2_load", 32'(rd_load), 32'd1);
        checkOutput("r2_no_wr", 32'(reg_wr_en), 32'd0);
        idleCycle();
        checkOutput("r_load_drop", 32'(rd_load), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("r_end_busy", 32'(busy), 32'd0);
        checkOutput("r_end_sel_hold", 32'(rd_sel), 32'd7);

        $display("[TB] wrap / overrun 0x0F,0x11,0x22");
        applyStimulus(8'h0F, 1'b1, 1'b0);
        applyStimulus(8'h11, 1'b1, 1'b0);
        checkOutput("wr15_en", 32'(reg_wr_en), 32'd1);
        checkOutput("wr15_addr", 32'(reg_wr_addr), 32'd15);
        checkOutput("wr15_data", 32'(reg_wr_data), 32'h11);
        checkOutput("nw15_en", 32'(nw_reg_wr_en), 32'd1);
        checkOutput("nw15_addr", 32'(nw_reg_wr_addr), 32'd15);
        checkOutput("nw15_err", 32'(nw_addr_err), 32'd1);
        applyStimulus(8'h22, 1'b1, 1'b0);
        checkOutput("wr0_en", 32'(reg_wr_en), 32'd1);
        checkOutput("wr0_addr", 32'(reg_wr_addr), 32'd0);
        checkOutput("wr0_data", 32'(reg_wr_data), 32'h22);
        checkOutput("wr0_err", 32'(addr_err), 32'd0);
        checkOutput("nw_drop_en", 32'(nw_reg_wr_en), 32'd0);
        checkOutput("nw_drop_busy", 32'(nw_busy), 32'd1);
        checkOutput("nw_drop_count", 32'(nw_wr_count), 32'd1);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("nw_end_busy", 32'(nw_busy), 32'd0);
        checkOutput("nw_end_err_hold", 32'(nw_addr_err), 32'd1);

        $display("[TB] bad address 0x20");
        applyStimulus(8'h20, 1'b1, 1'b0);
        checkOutput("bad_err", 32'(addr_err), 32'd1);
        checkOutput("bad_busy", 32'(busy), 32'd1);
        applyStimulus(8'h55, 1'b1, 1'b0);
        checkOutput("bad_no_wr", 32'(reg_wr_en), 32'd0);
        checkOutput("bad_no_load", 32'(rd_load), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b1);
        checkOutput("bad_end_err", 32'(addr_err), 32'd1);
        applyStimulus(8'h01, 1'b1, 1'b0);
        checkOutput("bad_clr_err", 32'(addr_err), 32'd0);
        checkOutput("bad_clr_busy", 32'(busy), 32'd1);
        applyStimulus(8'h00, 1'b0, 1'b1);

        $display("[TB] reset mid-frame");
        applyStimulus(8'h02, 1'b1, 1'b0);
        applyStimulus(8'h10, 1'b1, 1'b0);
        checkOutput("pre_rst_en", 32'(reg_wr_en), 32'd1);
        checkOutput("pre_rst_addr", 32'(reg_wr_addr), 32'd2);
        byte_in    = 8'h33;
        byte_valid = 1'b1;
        #1 rstn = 1'b0;
        #1;
        checkOutput("rst_mid_busy", 32'(busy), 32'd0);
        checkOutput("rst_mid_addr", 32'(reg_wr_addr), 32'd0);
        checkOutput("rst_mid_data", 32'(reg_wr_data), 32'd0);
        checkOutput("rst_mid_count", 32'(wr_count), 32'd0);
        @(negedge iclk);
        checkOutput("rst_mid_lost", 32'(reg_wr_en), 32'd0);
        byte_valid = 1'b0;
        rstn       = 1'b1;
        applyStimulus(8'h81, 1'b1, 1'b0);
        checkOutput("post_rst_cmd_sel", 32'(rd_sel), 32'd1);
        checkOutput("post_rst_cmd_load", 32'(rd_load), 32'd1);
        checkOutput("post_rst_cmd_no_wr", 32'(reg_wr_en), 32'd0);
        applyStimulus(8'h00, 1'b0, 1'b1);

        $display("[TB] byte_valid with frame_end");
        applyStimulus(8'h02, 1'b1, 1'b0);
        applyStimulus(8'h5A, 1'b1, 1'b1);
        checkOutput("tail_en", 32'(reg_wr_en), 32'd1);
        checkOutput("tail_addr", 32'(reg_wr_addr), 32'd2);
        checkOutput("tail_data", 32'(reg_wr_data), 32'h5A);
        checkOutput("tail_idle", 32'(busy), 32'd0);
        applyStimulus(8'h84, 1'b1, 1'b1);
        checkOutput("idle_cmd_drop_busy", 32'(busy), 32'd0);
        checkOutput("idle_cmd_drop_load", 32'(rd_load), 32'd0);
        checkOutput("idle_cmd_drop_wr", 32'(reg_wr_en), 32'd0);
        idleCycle();

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
